// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and grant helpers for the 4-way request arbiter.
// Policy is chosen at build time by ARB_ROUND_ROBIN_EN (see arb_pick4).
package arb_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;

  localparam logic [NREQ-1:0] GNT_NONE = '0;

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] v;
    v     = GNT_NONE;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_pick4.sv
// Combinational winner select over four requests with optional exclusion mask.
// ARB_ROUND_ROBIN_EN defined: rotating search from ptr; otherwise req[3] has top priority.
module arb_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] win_id,
  output logic            win_valid
);

  logic [NREQ-1:0] req_m;
  logic [NREQ-1:0] eff;

  // The mask only excludes a requester when someone else is asking.
  assign req_m     = req & ~mask;
  assign eff       = (req_m != '0) ? req_m : req;
  assign win_valid = |eff;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] idx;

  // Walk downward so the closest set bit at or above ptr is written last.
  always_comb begin
    win_id = '0;
    idx    = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (eff[idx]) win_id = idx;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win_id = '0;
    for (int k = 0; k < NREQ; k++)
      if (eff[k]) win_id = ID_W'(k);
  end
`endif

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: registered one-hot grant, hold limit with timeout pulse,
// one idle cycle between grants. ARB_ROUND_ROBIN_EN enables the round-robin pointer.
module req_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int              HC_W      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [1:0]      state;
  logic [HC_W-1:0] hold_cnt;
  logic [NREQ-1:0] mask;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic            win_valid;
  logic            do_grant;
  logic            released;
  logic            expired;

  arb_pick4 u_pick (
    .req       (req),
    .mask      (mask),
    .ptr       (ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    do_grant = ((state == IDLE) || (state == GAP)) && win_valid;
    released = !req[gnt_id];
    expired  = HOLD_EN && (hold_cnt == HOLD_LAST);
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  assign ptr = rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_ptr <= '0;
    else if (do_grant) rr_ptr <= win_id + 2'd1;
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      mask      <= '0;
      gnt       <= GNT_NONE;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          // Release wins over expiry on the same edge, so no timeout then.
          if (released || expired) begin
            state     <= GAP;
            gnt       <= GNT_NONE;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= !released;
            mask      <= released ? GNT_NONE : onehot(gnt_id);
          end else if (HOLD_EN && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        IDLE, GAP: begin
          timeout <= 1'b0;
          mask    <= GNT_NONE;
          if (do_grant) begin
            state     <= GRANT;
            gnt       <= onehot(win_id);
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= GNT_NONE;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
          mask      <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed scoreboard bench for req_arbiter4: u0 has MAX_HOLD=4, u1 has MAX_HOLD=0.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_req_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req, req1;
  logic [3:0] gnt, gnt1;
  logic [1:0] gnt_id, gnt_id1;
  logic       gnt_valid, gnt_valid1;
  logic       timeout, timeout1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  req_arbiter4 #(.MAX_HOLD(4)) u0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .gnt_valid(gnt_valid), .timeout(timeout)
  );

  req_arbiter4 #(.MAX_HOLD(0)) u1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .gnt_id(gnt_id1),
    .gnt_valid(gnt_valid1), .timeout(timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Packed view {gnt, gnt_id, gnt_valid, timeout}
  function automatic logic [7:0] expv(input logic [3:0] g, input logic to);
    return {g, enc(g), |g, to};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed gnt/id/vld/to=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic cyc(input bit which, input logic [3:0] r, input logic [3:0] eg,
                     input logic et, input string tag);
    exp_t e;
    if (which) req1 = r; else req = r;
    e.gnt = eg; e.to = et; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (which) chk(e.tag, {gnt1, gnt_id1, gnt_valid1, timeout1}, expv(e.gnt, e.to));
    else       chk(e.tag, {gnt, gnt_id, gnt_valid, timeout}, expv(e.gnt, e.to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    req1 = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    req1 = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u0", {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
    chk("reset_u1", {gnt1, gnt_id1, gnt_valid1, timeout1}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // 1: async reset mid-grant of owner 2
    cyc(0, 4'b0100, 4'b0100, 0, "t1_g2_first");
    cyc(0, 4'b0100, 4'b0100, 0, "t1_g2_hold");
    rst = 1'b1;
    #1;
    chk("t1_rst_async", {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 4'b0010, 4'b0010, 0, "t1_after_rst");
    cyc(0, 4'b0000, 4'b0000, 0, "t1_release_gap");
    cyc(0, 4'b0000, 4'b0000, 0, "t1_idle");

    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    // 3: round robin 0,1,2,3,0 with two-cycle grants
    cyc(0, 4'b1111, 4'b0001, 0, "t3_g0a");
    cyc(0, 4'b1111, 4'b0001, 0, "t3_g0b");
    cyc(0, 4'b1110, 4'b0000, 0, "t3_gap0");
    cyc(0, 4'b1111, 4'b0010, 0, "t3_g1a");
    cyc(0, 4'b1111, 4'b0010, 0, "t3_g1b");
    cyc(0, 4'b1101, 4'b0000, 0, "t3_gap1");
    cyc(0, 4'b1111, 4'b0100, 0, "t3_g2a");
    cyc(0, 4'b1111, 4'b0100, 0, "t3_g2b");
    cyc(0, 4'b1011, 4'b0000, 0, "t3_gap2");
    cyc(0, 4'b1111, 4'b1000, 0, "t3_g3a");
    cyc(0, 4'b1111, 4'b1000, 0, "t3_g3b");
    cyc(0, 4'b0111, 4'b0000, 0, "t3_gap3");
    cyc(0, 4'b1111, 4'b0001, 0, "t3_g0_again");
`else
    // 2: fixed priority, 2 beats 0, then one gap
    cyc(0, 4'b0101, 4'b0100, 0, "t2_prio_g2");
    cyc(0, 4'b0001, 4'b0000, 0, "t2_gap");
    cyc(0, 4'b0001, 4'b0001, 0, "t2_g0");
`endif
    cyc(0, 4'b0000, 4'b0000, 0, "rel_gap");
    cyc(0, 4'b0000, 4'b0000, 0, "rel_idle");

    // 4: owner 3 hits the limit, masked in favour of 0; 0 then times out to 3
    cyc(0, 4'b1000, 4'b1000, 0, "t4_g3_c1");
    cyc(0, 4'b1001, 4'b1000, 0, "t4_g3_c2");
    cyc(0, 4'b1001, 4'b1000, 0, "t4_g3_c3");
    cyc(0, 4'b1001, 4'b1000, 0, "t4_g3_c4");
    cyc(0, 4'b1001, 4'b0000, 1, "t4_timeout3");
    cyc(0, 4'b1001, 4'b0001, 0, "t4_g0_c1");
    cyc(0, 4'b1001, 4'b0001, 0, "t4_g0_c2");
    cyc(0, 4'b1001, 4'b0001, 0, "t4_g0_c3");
    cyc(0, 4'b1001, 4'b0001, 0, "t4_g0_c4");
    cyc(0, 4'b1001, 4'b0000, 1, "t4_timeout0");
    cyc(0, 4'b1001, 4'b1000, 0, "t4_g3_again");
    cyc(0, 4'b0000, 4'b0000, 0, "t4_gap");
    cyc(0, 4'b0000, 4'b0000, 0, "t4_idle");

    // 5: sole requester is re-granted after each timeout
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 4; c++) cyc(0, 4'b0100, 4'b0100, 0, "t5_grant");
      cyc(0, 4'b0100, 4'b0000, 1, "t5_timeout");
    end
    cyc(0, 4'b0100, 4'b0100, 0, "t5_regrant");
    cyc(0, 4'b0000, 4'b0000, 0, "t5_gap");
    cyc(0, 4'b0000, 4'b0000, 0, "t5_idle");

    // 6a: release on the expiry edge is a plain release; 1-cycle minimum grant
    for (int c = 0; c < 4; c++) cyc(0, 4'b0010, 4'b0010, 0, "t6_grant");
    cyc(0, 4'b0000, 4'b0000, 0, "t6_release_at_limit");
    cyc(0, 4'b0000, 4'b0000, 0, "t6_idle");
    cyc(0, 4'b0010, 4'b0010, 0, "t6_min_grant");
    cyc(0, 4'b0000, 4'b0000, 0, "t6_min_gap");
    cyc(0, 4'b0000, 4'b0000, 0, "t6_min_idle");

    // 6b: unlimited hold on u1
    for (int c = 0; c < 300; c++) cyc(1, 4'b0001, 4'b0001, 0, "t6_unlimited");
    cyc(1, 4'b0000, 4'b0000, 0, "t6_unl_gap");
    cyc(1, 4'b0000, 4'b0000, 0, "t6_unl_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Output invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(gnt) > 1 || (gnt_valid !== |gnt) || (!gnt_valid && gnt_id !== 2'd0)) begin
        errors++;
        $error("FAIL inv_u0: observed gnt=%b id=%0d vld=%b required one-hot consistent", gnt, gnt_id, gnt_valid);
      end
      if ($countones(gnt1) > 1 || (gnt_valid1 !== |gnt1) || timeout1 !== 1'b0) begin
        errors++;
        $error("FAIL inv_u1: observed gnt=%b vld=%b to=%b required consistent, no timeout", gnt1, gnt_valid1, timeout1);
      end
    end
  end

endmodule

// File: doc/req_arbiter4.md
Name: req_arbiter4

Overview:
Four-requester arbiter that shares one downstream resource, such as the priority-encoded datapath, between independent requesters.
- Samples a 4-bit request vector and issues a registered one-hot grant plus a 2-bit encoded grant index.
- Holds the grant until the owner releases it or a hold limit expires.
- Inserts exactly one idle cycle between consecutive grants.
- Sits between requester logic and the shared resource's select/enable inputs.

Parameters:
- MAX_HOLD, 8: max consecutive GRANT cycles per ownership; 0 = unlimited; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request vector; req[i] held high while requester i wants or uses the resource
- gnt  output 4  one-hot grant, registered; all-zero when no owner
- gnt_id  output 2  binary index of current owner; 0 when gnt_valid=0
- gnt_valid  output 1  high while any grant is active (equals OR of gnt)
- timeout  output 1  one-cycle pulse, asserted the cycle after a grant is revoked by MAX_HOLD

Behaviour:
Reset (rst=1, asynchronous, effective immediately, also mid-grant):
- gnt=0, gnt_id=0, gnt_valid=0, timeout=0
- state=IDLE, hold_cnt=0, rr_ptr=0, mask=0

States:
- IDLE: no grant. If req!=0 at a clock edge, latch the winner, go to GRANT. Grant is visible in the cycle after the sampling edge (latency 1 cycle).
- GRANT: gnt/gnt_id/gnt_valid reflect the owner; hold_cnt increments each cycle starting from 0 on entry.
  - If req[owner]==0 at an edge: go to GAP, no timeout.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: go to GAP and assert timeout during the GAP cycle.
  - Else stay in GRANT.
  - Grant length is therefore at most MAX_HOLD cycles.
- GAP: exactly one cycle with gnt=0.
  - If req (after masking) !=0 at the edge: pick a winner, go to GRANT.
  - Else go to IDLE.
  - Back-to-back grants are separated by exactly one zero cycle.

Arbitration rules:
- Winner selection uses only req values sampled at the arbitration edge.
- Requests dropped before sampling are lost; no request memory.
- Simultaneous release and MAX_HOLD expiry in the same cycle counts as a normal release: timeout stays 0.
- A winner that drops req in its first GRANT cycle is released at the next edge. Minimum grant is 1 cycle.
- After a timeout, the revoked owner is masked out of the arbitration in the following GAP cycle only if another request is present. If it is the sole requester, it is re-granted.

Counter:
- hold_cnt width is $clog2(MAX_HOLD+1), minimum 1 bit.
- Saturating, never wraps.
- Cleared on entry to GRANT.
- Unused when MAX_HOLD=0.

Output invariants: at most one gnt bit high, and gnt only in GRANT state.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN selects the arbitration policy.
- Defined (round-robin):
  - Search starts at rr_ptr and goes upward modulo 4; the first set request wins.
  - On each grant, rr_ptr becomes (winner+1) mod 4.
  - The timeout mask still applies.
- Undefined (fixed priority): req[3] > req[2] > req[1] > req[0], matching the priority-encoder ordering.
  - rr_ptr is not implemented.

Decomposition:
- Package arb_pkg:
  - NREQ=4 and ID_W=2
  - state encoding IDLE=2'b00, GRANT=2'b01, GAP=2'b10
  - helper constant for the all-zero grant
- Sub-module arb_pick4, combinational:
  - inputs: req[3:0], mask[3:0], ptr[1:0]
  - outputs: win_id[1:0], win_valid
  - the ARB_ROUND_ROBIN_EN policy is selected inside this sub-module
- The top level holds the FSM, hold counter, pointer, mask and output registers.

Test Plan:
1. Reset behaviour: assert rst mid-GRANT (owner 2) between edges → gnt=0000, gnt_valid=0, gnt_id=0 immediately, without waiting for a clock edge. After release, req=0010 → gnt=0010 one cycle after the sampling edge.
2. Fixed priority, macro undefined: req=0101 sampled at edge → gnt=0100, gnt_id=2. Drop req[2] → one GAP cycle with gnt=0000, then gnt=0001, gnt_id=0.
3. Round-robin, macro defined, rr_ptr=0: req=1111 held, each owner drops req after 2 cycles, then re-raises → grants cycle 0,1,2,3,0. Each grant is 2 cycles, separated by one zero cycle.
4. Timeout, MAX_HOLD=4: req=1000 held permanently, plus req=0001 → gnt=1000 for exactly 4 cycles, then GAP with timeout=1, then gnt=0001 (1000 masked).
5. Sole requester timeout, MAX_HOLD=4: req=0100 held alone → grants of 4 cycles each, separated by one GAP with timeout=1, re-granted indefinitely.
6. Release and expiry in the same edge: owner drops req in cycle MAX_HOLD-1 → GAP with timeout=0. MAX_HOLD=0 → a grant held 300 cycles never times out.
